cardinal_nic: RTL
=================

# cardinal_nic

Network interface between a processing element's memory-mapped port and a cardinal router's PE channel. It holds one 64-bit packet in each direction and exposes data and status words on a 2-bit address. Outbound packets reach the router's PE input only in the clock phase whose polarity matches the packet's virtual-channel bit. Inbound packets from the router's PE output are buffered until the processor reads them.

## Interface
Parameters:
- DATA_W, 64, packet and processor data width
- VC_BIT, 63, packet bit that selects the virtual channel (0 = even, 1 = odd)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- addr  in  2  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status
- d_in  in  DATA_W  processor write data
- d_out  out  DATA_W  processor read data, registered
- nic_en  in  1  access strobe
- nic_wr_en  in  1  1 = write, 0 = read; only meaningful with nic_en
- net_so  out  1  send to router PE input
- net_ro  in  1  router PE input ready
- net_do  out  DATA_W  packet to router
- net_polarity  in  1  router polarity (0 even, 1 odd)
- net_si  in  1  send from router PE output
- net_ri  out  1  ready to router
- net_di  in  DATA_W  packet from router

## Operation
State:
- in_buf, in_full: inbound packet and its flag
- out_buf, out_full: outbound packet and its flag

Inbound path:
- net_ri = ~in_full, combinational.
- When net_si & net_ri at a clock edge: in_buf <= net_di and in_full <= 1.

Processor reads (nic_en & ~nic_wr_en), d_out loaded at the edge:
- addr 00: d_out <= in_buf, and in_full <= 0 on the same edge.
- addr 01: d_out <= {63'b0, in_full}.
- addr 11: d_out <= {63'b0, out_full}.
- addr 10: d_out <= 0.
- No read in a cycle: d_out holds its value.

Processor writes (nic_en & nic_wr_en):
- addr 10 with out_full = 0: out_buf <= d_in and out_full <= 1.
- addr 10 with out_full = 1: write dropped, nothing changes.
- Writes to addresses 00, 01 and 11 are ignored.

Outbound path:
- net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity), combinational.
- net_do = out_buf.
- When net_so = 1 at an edge: out_full <= 0.

Same-edge events:
- Processor write to 10 in the cycle net_so = 1: out_full is 1 at that point, so the write is dropped. Software polls addr 11 before writing.
- Inbound arrival and a read of 00 at the same edge cannot occur, because net_ri = 0 whenever in_full = 1.
- Reading 01 and receiving at the same edge: d_out shows the pre-edge flag (0).

## Timing
- Reset values: d_out = 0, in_full = 0, out_full = 0, in_buf = 0, out_buf = 0. Hence net_ri = 1 and net_so = 0 after reset.
- Inbound: arriving at edge N, the packet is visible through an addr 00 read issued in cycle N+1; d_out is valid after edge N+1.
- Outbound: after a write at edge N, net_so can first rise in cycle N+1, provided polarity matches and net_ro = 1. Otherwise it waits. Worst case is 1 extra cycle for polarity, plus any router back-pressure.
- Reset mid-transfer: any buffered packet is discarded. A net_si presented in a reset cycle is not captured.
- Throughput: one packet per direction every 2 cycles (fill then drain). Outbound may be further limited by polarity.

## Structure
- Shared package holds: NIC_ADDR_IN_BUF = 2'b00, NIC_ADDR_IN_STAT = 2'b01, NIC_ADDR_OUT_BUF = 2'b10, NIC_ADDR_OUT_STAT = 2'b11, the VC bit index, and the packet field positions used by the routers.
- One sub-module, nic_buffer: a single-entry register with full flag, load, and clear. It is instantiated twice, once for inbound and once for outbound. The address decode and d_out mux stay in the top level.

## Test plan
- Reset, then read 01 and 11: d_out = 0 both times; net_ri = 1, net_so = 0.
- Write 0x8000_0000_0000_00AA to addr 10 with net_ro = 1 and net_polarity = 0: net_so stays 0. On the next cycle, with polarity = 1, net_so = 1 and net_do = 0x8000_0000_0000_00AA; out_full then reads 0.
- With out_full = 1 and net_ro = 0, write 0x55 to addr 10: it is dropped. Once net_ro is raised, the original packet is sent, not 0x55.
- Drive net_si = 1 with net_di = 0x1234: net_ri falls the next cycle and a read of 01 returns 1. Reading 00 returns 0x1234; the next read of 01 returns 0 and net_ri = 1.
- Hold net_si = 1 continuously with values 0x1 then 0x2: only 0x1 is captured until 00 is read, after which 0x2 is accepted.
- Assert reset while in_full = 1 and out_full = 1: the next cycle shows net_ri = 1, net_so = 0, and d_out = 0.

Source files
------------

// File: rtl/cardinal_nic_pkg.sv
// rtl/cardinal_nic_pkg.sv - shared register map and packet layout for the cardinal NIC
package cardinal_nic_pkg;

  localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

  localparam int PKT_W          = 64;
  localparam int PKT_VC_BIT     = 63;
  localparam int PKT_DIR_BIT    = 62;
  localparam int PKT_HOP_HI     = 55;
  localparam int PKT_HOP_LO     = 48;
  localparam int PKT_PAYLOAD_HI = 31;
  localparam int PKT_PAYLOAD_LO = 0;

  function automatic logic pkt_vc(input logic [PKT_W-1:0] pkt);
    return pkt[PKT_VC_BIT];
  endfunction

endpackage

// File: rtl/cardinal_nic_buffer.sv
// rtl/cardinal_nic_buffer.sv - single-entry packet register with full flag
module nic_buffer #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);

  // Load wins over clear so an arriving packet is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cardinal_nic.sv
// rtl/cardinal_nic.sv - memory-mapped PE port to cardinal router PE channel bridge
module cardinal_nic
  import cardinal_nic_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int VC_BIT = PKT_VC_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nic_en,
  input  logic              nic_wr_en,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);

  logic              rd;
  logic              wr;
  logic              in_full;
  logic              in_load;
  logic              in_clear;
  logic [DATA_W-1:0] in_buf;
  logic              out_full;
  logic              out_load;
  logic [DATA_W-1:0] out_buf;

  assign rd = nic_en & ~nic_wr_en;
  assign wr = nic_en & nic_wr_en;

  assign net_ri   = ~in_full;
  assign in_load  = net_si & ~in_full;
  assign in_clear = rd & (addr == NIC_ADDR_IN_BUF);

  // A write into a still-occupied outbound slot is silently dropped.
  assign out_load = wr & (addr == NIC_ADDR_OUT_BUF) & ~out_full;
  assign net_so   = out_full & net_ro & (out_buf[VC_BIT] == net_polarity);
  assign net_do   = out_buf;

  nic_buffer #(.W(DATA_W)) u_in_buf (
    .clk   (clk),
    .reset (reset),
    .load  (in_load),
    .clear (in_clear),
    .d     (net_di),
    .q     (in_buf),
    .full  (in_full)
  );

  nic_buffer #(.W(DATA_W)) u_out_buf (
    .clk   (clk),
    .reset (reset),
    .load  (out_load),
    .clear (net_so),
    .d     (d_in),
    .q     (out_buf),
    .full  (out_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      d_out <= '0;
    end else if (rd) begin
      case (addr)
        NIC_ADDR_IN_BUF:   d_out <= in_buf;
        NIC_ADDR_IN_STAT:  d_out <= {{(DATA_W-1){1'b0}}, in_full};
        NIC_ADDR_OUT_STAT: d_out <= {{(DATA_W-1){1'b0}}, out_full};
        default:           d_out <= '0;
      endcase
    end
  end

endmodule
